nfa_match_reporter: RTL and testbench

Downstream stage of the NFA regex engine. It samples the per-rule match outputs of the rule blocks (one `out` bit per constraint or rule module) on every consumed character and stamps each non-zero match vector with the byte offset of the character that produced it. Events are buffered in a small FIFO and presented to the host/report bus over a valid/ready handshake. Sticky status flags report offset saturation and dropped events.

---
 rtl/nfa_report_pkg.sv | 18 +
 rtl/report_fifo.sv | 69 ++++++
 rtl/nfa_match_reporter.sv | 101 ++++++++++
 tb/tb_nfa_match_reporter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/nfa_report_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nfa_report_pkg
// Description : Shared constants and event record for the NFA match reporter.
// Revision    : 1.0 - initial release
// ============================================================================
package nfa_report_pkg;

    localparam int NUM_RULES_DEF = 8;
    localparam int OFF_W_DEF     = 16;

    typedef struct packed {
        logic [NUM_RULES_DEF-1:0] vec;
        logic [OFF_W_DEF-1:0]     off;
    } match_evt_t;

endpackage : nfa_report_pkg
`default_nettype wire

// File: rtl/report_fifo.sv
`default_nettype none
// ============================================================================
// Module      : report_fifo
// Description : Synchronous FIFO with extra-bit pointers; accepts a push while
//               full when a pop happens on the same edge.
// Revision    : 1.0 - initial release
// ============================================================================
module report_fifo
    import nfa_report_pkg::*;
#(
    parameter int WIDTH = NUM_RULES_DEF + OFF_W_DEF,
    parameter int DEPTH = 4
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw:0]    r_wptr;
    logic [c_aw:0]    r_rptr;

    logic w_full;
    logic w_empty;
    logic w_do_pop;
    logic w_do_push;

    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = (r_wptr[c_aw] != r_rptr[c_aw]) &&
                       (r_wptr[c_aw-1:0] == r_rptr[c_aw-1:0]);
    assign w_do_pop  = i_pop && !w_empty;
    // The slot being vacated by the pop is the one the push overwrites.
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr[c_aw-1:0]] <= i_wdata;
        end
    end

    assign o_rdata = w_empty ? '0 : r_mem[r_rptr[c_aw-1:0]];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_level = r_wptr - r_rptr;

endmodule : report_fifo
`default_nettype wire

// File: rtl/nfa_match_reporter.sv
`default_nettype none
// ============================================================================
// Module      : nfa_match_reporter
// Description : Stamps non-zero rule match vectors with their byte offset and
//               queues them for the report bus, with sticky status flags.
// Revision    : 1.0 - initial release
// ============================================================================
module nfa_match_reporter
    import nfa_report_pkg::*;
#(
    parameter int NUM_RULES = NUM_RULES_DEF,
    parameter int OFF_W     = OFF_W_DEF,
    parameter int DEPTH     = 4
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     sos,
    input  logic [NUM_RULES-1:0]     match,
    input  logic                     clr_stat,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [NUM_RULES-1:0]     m_vec,
    output logic [OFF_W-1:0]         m_off,
    output logic                     ovf,
    output logic                     off_sat,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int               c_evt_w   = NUM_RULES + OFF_W;
    localparam logic [OFF_W-1:0] c_off_max = '1;

    logic [OFF_W-1:0]   r_off;
    logic               r_ovf;
    logic               r_off_sat;

    logic [OFF_W-1:0]   w_cur_off;
    logic               w_at_max;
    logic               w_evt;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic               w_drop;
    logic [c_evt_w-1:0] w_rdata;

    assign w_cur_off = sos ? '0 : r_off;
    assign w_at_max  = (w_cur_off == c_off_max);
    assign w_evt     = en && (match != '0);
    assign w_pop     = !w_empty && m_ready;
    assign w_drop    = w_evt && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_off <= '0;
        end else if (en) begin
            r_off <= w_at_max ? c_off_max : w_cur_off + OFF_W'(1);
        end
    end

    // Set conditions take priority over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf     <= 1'b0;
            r_off_sat <= 1'b0;
        end else begin
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (clr_stat) begin
                r_ovf <= 1'b0;
            end
            if (en && w_at_max) begin
                r_off_sat <= 1'b1;
            end else if (clr_stat) begin
                r_off_sat <= 1'b0;
            end
        end
    end

    report_fifo #(
        .WIDTH (c_evt_w),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_evt),
        .i_pop   (w_pop),
        .i_wdata ({match, w_cur_off}),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level)
    );

    assign m_valid = !w_empty;
    assign m_vec   = w_rdata[OFF_W +: NUM_RULES];
    assign m_off   = w_rdata[OFF_W-1:0];
    assign ovf     = r_ovf;
    assign off_sat = r_off_sat;

endmodule : nfa_match_reporter
`default_nettype wire

// File: tb/tb_nfa_match_reporter.sv
`default_nettype none
// ============================================================================
// Module      : tb_nfa_match_reporter
// Description : Directed and random checks of two reporter instances (16-bit
//               and 4-bit offsets) against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nfa_match_reporter;
    import nfa_report_pkg::*;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst, en, sos, clr_stat, m_ready;
    logic [7:0] match;

    logic        v0, ovf0, sat0;
    logic [7:0]  vec0;
    logic [15:0] off0;
    logic [2:0]  lvl0;
    logic        v1, ovf1, sat1;
    logic [7:0]  vec1;
    logic [3:0]  off1;
    logic [2:0]  lvl1;

    int errors = 0;
    int checks = 0;

    match_evt_t mq [2][$];
    int         moff [2];
    bit         movf [2];
    bit         msat [2];
    int         omax [2] = '{65535, 15};

    always #5 clk = ~clk;

    nfa_match_reporter #(.NUM_RULES(8), .OFF_W(16), .DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst(rst), .en(en), .sos(sos), .match(match), .clr_stat(clr_stat),
        .m_valid(v0), .m_ready(m_ready), .m_vec(vec0), .m_off(off0),
        .ovf(ovf0), .off_sat(sat0), .level(lvl0)
    );

    nfa_match_reporter #(.NUM_RULES(8), .OFF_W(4), .DEPTH(DEPTH)) u_dut4 (
        .clk(clk), .rst(rst), .en(en), .sos(sos), .match(match), .clr_stat(clr_stat),
        .m_valid(v1), .m_ready(m_ready), .m_vec(vec1), .m_off(off1),
        .ovf(ovf1), .off_sat(sat1), .level(lvl1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int cur;
        bit pop, evt, drop;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                mq[i].delete();
                moff[i] = 0;
                movf[i] = 0;
                msat[i] = 0;
            end else begin
                cur  = sos ? 0 : moff[i];
                pop  = (mq[i].size() > 0) && m_ready;
                evt  = en && (match != 8'h00);
                drop = evt && (mq[i].size() == DEPTH) && !pop;
                if (pop) void'(mq[i].pop_front());
                if (evt && !drop) mq[i].push_back('{vec: match, off: 16'(cur)});
                if (drop) movf[i] = 1;
                else if (clr_stat) movf[i] = 0;
                if (en && cur == omax[i]) msat[i] = 1;
                else if (clr_stat) msat[i] = 0;
                if (en) moff[i] = (cur + 1 > omax[i]) ? omax[i] : cur + 1;
            end
        end
    endtask

    task automatic check_all();
        bit ne0, ne1;
        ne0 = mq[0].size() > 0;
        ne1 = mq[1].size() > 0;
        chk("valid0", 32'(v0), 32'(ne0));
        chk("vec0",   32'(vec0), ne0 ? 32'(mq[0][0].vec) : 32'd0);
        chk("off0",   32'(off0), ne0 ? 32'(mq[0][0].off) : 32'd0);
        chk("level0", 32'(lvl0), 32'(mq[0].size()));
        chk("ovf0",   32'(ovf0), 32'(movf[0]));
        chk("sat0",   32'(sat0), 32'(msat[0]));
        chk("valid1", 32'(v1), 32'(ne1));
        chk("vec1",   32'(vec1), ne1 ? 32'(mq[1][0].vec) : 32'd0);
        chk("off1",   32'(off1), ne1 ? 32'(mq[1][0].off) : 32'd0);
        chk("level1", 32'(lvl1), 32'(mq[1].size()));
        chk("ovf1",   32'(ovf1), 32'(movf[1]));
        chk("sat1",   32'(sat1), 32'(msat[1]));
    endtask

    task automatic cyc(input logic r, input logic e, input logic s, input logic [7:0] m,
                       input logic rdy, input logic clr);
        rst = r; en = e; sos = s; match = m; m_ready = rdy; clr_stat = clr;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; sos = 1'b0; match = 8'h00; m_ready = 1'b0; clr_stat = 1'b0;

        // Reset state
        cyc(1, 0, 0, 8'h00, 0, 0);
        cyc(1, 1, 0, 8'hFF, 1, 0);
        chk("rst_valid", 32'(v0), 32'd0);
        chk("rst_level", 32'(lvl0), 32'd0);

        // Five idle characters, then a match at offset 5
        for (int c = 0; c < 5; c++) cyc(0, 1, 0, 8'h00, 0, 0);
        chk("pre_evt_valid", 32'(v0), 32'd0);
        cyc(0, 1, 0, 8'h04, 0, 0);
        chk("lat_valid", 32'(v0), 32'd1);
        chk("first_vec", 32'(vec0), 32'h04);
        chk("first_off", 32'(off0), 32'd5);
        cyc(0, 0, 0, 8'h00, 1, 0);

        // Start of stream mid-stream
        cyc(0, 1, 1, 8'h81, 0, 0);
        chk("sos_off", 32'(off0), 32'd0);
        cyc(0, 1, 0, 8'h01, 1, 0);
        chk("sos_next_off", 32'(off0), 32'd1);
        cyc(0, 0, 0, 8'h00, 1, 0);
        chk("drained", 32'(lvl0), 32'd0);

        // Overflow with consumer stalled, then clear keeps entries
        for (int c = 0; c < 5; c++) cyc(0, 1, 0, 8'(c + 1), 0, 0);
        chk("ovf_level", 32'(lvl0), 32'd4);
        chk("ovf_flag", 32'(ovf0), 32'd1);
        chk("ovf_head", 32'(vec0), 32'h01);
        cyc(0, 0, 0, 8'h00, 0, 1);
        chk("clr_ovf", 32'(ovf0), 32'd0);
        chk("clr_level", 32'(lvl0), 32'd4);

        // Full FIFO with simultaneous push and pop
        cyc(0, 1, 0, 8'h55, 1, 0);
        chk("fullpp_level", 32'(lvl0), 32'd4);
        chk("fullpp_ovf", 32'(ovf0), 32'd0);
        chk("fullpp_head", 32'(vec0), 32'h02);
        for (int c = 0; c < 5; c++) cyc(0, 0, 0, 8'h00, 1, 0);

        // Offset saturation on the 4-bit instance
        cyc(1, 0, 0, 8'h00, 0, 0);
        for (int c = 1; c <= 20; c++) begin
            cyc(0, 1, 0, (c == 17) ? 8'h10 : 8'h00, 0, 0);
            if (c == 17) begin
                chk("sat_off4", 32'(off1), 32'd15);
                chk("sat_flag4", 32'(sat1), 32'd1);
                chk("sat_off16", 32'(off0), 32'd16);
                chk("sat_flag16", 32'(sat0), 32'd0);
            end
        end

        // Reset with queued entries and a coincident event
        cyc(1, 0, 0, 8'h00, 0, 0);
        for (int c = 0; c < 3; c++) cyc(0, 1, 0, 8'h20, 0, 0);
        chk("pre_rst_level", 32'(lvl0), 32'd3);
        cyc(1, 1, 0, 8'hFF, 0, 0);
        chk("mid_rst_valid", 32'(v0), 32'd0);
        chk("mid_rst_level", 32'(lvl0), 32'd0);
        chk("mid_rst_ovf", 32'(ovf0), 32'd0);
        cyc(0, 1, 0, 8'h08, 0, 0);
        chk("post_rst_off", 32'(off0), 32'd0);

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            cyc(($urandom_range(0, 200) == 0),
                ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00,
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 20) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_nfa_match_reporter
`default_nettype wire
